// File: rtl/mmt_sync_filt.sv
// mmt_sync_filt
//   Multi-channel clock-domain entry cell. Each of WIDTH asynchronous inputs
//   passes through a STAGES-deep synchroniser and a per-channel debounce filter.
//   A registered edge detector follows the filter and can be left out.
//   The destination domain gets a clean level plus single-cycle rise/fall pulses.
//
// Ports
//   clk      destination-domain clock, rising edge
//   rstn     asynchronous, active-low reset
//   d        [WIDTH] asynchronous channel inputs
//   q        [WIDTH] synchronised, filtered level (registered)
//   rise     [WIDTH] one-cycle pulse when q[i] goes 0->1 (registered)
//   fall     [WIDTH] one-cycle pulse when q[i] goes 1->0 (registered)
//   chg_any  OR-reduction of (rise | fall)
module mmt_sync_filt #(
  parameter int unsigned      WIDTH   = 4,
  parameter int unsigned      STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      DEB_CYC = 0,
  parameter bit               EDGE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             chg_any
);

  localparam int unsigned      CNT_W  = (DEB_CYC == 0) ? 1 : $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC);

  generate
    if (STAGES < 2 || STAGES > 4 || WIDTH < 1) begin : g_bad_param
      $fatal(1, "mmt_sync_filt: STAGES must be 2..4 and WIDTH >= 1");
    end
  endgenerate

  // Synchroniser chain: plain flop-to-flop, nothing in between.
  logic [WIDTH-1:0] r_sync [STAGES];
  logic [WIDTH-1:0] w_sv;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < STAGES; k++) r_sync[k] <= RST_VAL;
    end else begin
      r_sync[0] <= d;
      for (int unsigned k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_sv = r_sync[STAGES-1];

  // Debounce: q[i] follows sv[i] only after sv[i] has differed from q[i]
  // for DEB_CYC+1 consecutive samples; any agreement restarts the count.
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt      [WIDTH];
  logic [CNT_W-1:0] w_cnt_next [WIDTH];
  logic [WIDTH-1:0] w_q_next;

  always_comb begin
    w_q_next = r_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = '0;
      if (w_sv[i] != r_q[i]) begin
        if (r_cnt[i] == CNT_MAX) w_q_next[i] = w_sv[i];
        else                     w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= RST_VAL;
      for (int unsigned i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_q <= w_q_next;
      for (int unsigned i = 0; i < WIDTH; i++) r_cnt[i] <= w_cnt_next[i];
    end
  end

  // Edge pulses are computed from q_next so they line up with the new q value.
  generate
    if (EDGE_EN) begin : g_edge
      logic [WIDTH-1:0] r_rise;
      logic [WIDTH-1:0] r_fall;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_rise <= '0;
          r_fall <= '0;
        end else begin
          r_rise <= w_q_next & ~r_q;
          r_fall <= ~w_q_next & r_q;
        end
      end

      assign rise = r_rise;
      assign fall = r_fall;
    end else begin : g_no_edge
      assign rise = '0;
      assign fall = '0;
    end
  endgenerate

  assign q       = r_q;
  assign chg_any = |(rise | fall);

endmodule
